// File: rtl/int_ctrl_if.sv
// int_ctrl_if: request, mask and CPU handshake bundle for int_ctrl.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

interface int_ctrl_if #(
  parameter int NUM_SRC = 4,
  parameter int CW      = $clog2(NUM_SRC)
);
  logic [NUM_SRC-1:0] src;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_in;
  logic               int_ack;
  logic               int_done;
  logic               err_clr;
  logic               ipu_int;
  logic [CW-1:0]      int_cause;
  logic               int_busy;
  logic [NUM_SRC-1:0] pending;
  logic               timeout_err;

  modport slave (
    input  src, mask_we, mask_in, int_ack, int_done, err_clr,
    output ipu_int, int_cause, int_busy, pending, timeout_err
  );

  modport master (
    output src, mask_we, mask_in, int_ack, int_done, err_clr,
    input  ipu_int, int_cause, int_busy, pending, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/int_ctrl.sv
// int_ctrl: edge-triggered, maskable, fixed-priority interrupt controller for the fetch stage.
// Optional acknowledge timeout enabled by INTC_TIMEOUT_EN. Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module int_ctrl #(
  parameter int                 NUM_SRC     = 4,
  parameter int                 CW          = $clog2(NUM_SRC),
  parameter logic [NUM_SRC-1:0] MASK_RST    = '1,
  parameter int                 ACK_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  int_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             state_q;
  logic               ipu_q;
  logic [CW-1:0]      cause_q;
  logic               busy_q;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] clr;
  logic [CW-1:0]      sel;

  assign rise = bus.src & ~src_q;
  assign elig = pending_q & mask_q;

  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) sel = CW'(i);
    end
  end

  always_comb begin
    clr = '0;
    if (state_q == S_REQ && bus.int_ack) clr[cause_q] = 1'b1;
  end

  // A new edge on the source being cleared wins over the clear.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      mask_q    <= MASK_RST;
      pending_q <= '0;
    end else begin
      src_q     <= bus.src;
      pending_q <= pending_d;
      if (bus.mask_we) mask_q <= bus.mask_in;
    end
  end

`ifdef INTC_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;
  logic       err_set;

  assign err_set = (state_q == S_REQ) && !bus.int_ack && (cnt_q == 8'(ACK_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end else if (bus.err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign bus.timeout_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg      = bus.err_clr ^ (ACK_TIMEOUT != 0);
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ipu_q   <= 1'b0;
      cause_q <= '0;
      busy_q  <= 1'b0;
`ifdef INTC_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|elig) begin
            state_q <= S_REQ;
            ipu_q   <= 1'b1;
            cause_q <= sel;
            busy_q  <= 1'b1;
`ifdef INTC_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        S_REQ: begin
          if (bus.int_ack) begin
            state_q <= S_SERVICE;
            ipu_q   <= 1'b0;
          end
`ifdef INTC_TIMEOUT_EN
          // Abandon the request but leave its pending bit for a retry.
          else if (err_set) begin
            state_q <= S_IDLE;
            ipu_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
          end
`endif
        end
        S_SERVICE: begin
          if (bus.int_done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ipu_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ipu_int   = ipu_q;
  assign bus.int_cause = cause_q;
  assign bus.int_busy  = busy_q;
  assign bus.pending   = pending_q;

endmodule

`default_nettype wire
